// File: rtl/led_matrix_scan_ctrl_if.sv
// Signal bundle between the LED scan controller and the game/panel side.
// master = controller, slave = game logic + panel drivers.
interface led_matrix_scan_ctrl_if;
  logic        enable;
  logic        blank;
  logic [3:0]  row_addr;
  logic [15:0] fb_data;
  logic        frame_start;
  logic        CSDI;
  logic        CCLK;
  logic        RSDI;
  logic        RCLK;
  logic        LE;
  logic        OEB;

  modport master (
    input  enable, blank, fb_data,
    output row_addr, frame_start, CSDI, CCLK, RSDI, RCLK, LE, OEB
  );
  modport slave (
    output enable, blank, fb_data,
    input  row_addr, frame_start, CSDI, CCLK, RSDI, RCLK, LE, OEB
  );
endinterface

// File: rtl/led_matrix_scan_ctrl.sv
// Row-scan sequencer for a 16x16 LED matrix: fetches a framebuffer row, shifts
// columns then the row-select bit, latches, and holds the row lit.
module led_matrix_scan_ctrl #(
  parameter int DIV  = 2,
  parameter int HOLD = 256
) (
  input  logic                   clk,
  input  logic                   reset_n,
  led_matrix_scan_ctrl_if.master bus
);
  localparam int MAXC = (32 * DIV > HOLD) ? 32 * DIV : HOLD;
  localparam int CW   = $clog2(MAXC);
  localparam logic [CW-1:0] BIT_END  = CW'(2 * DIV - 1);
  localparam logic [CW-1:0] LE_END   = CW'(DIV - 1);
  localparam logic [CW-1:0] HOLD_END = CW'(HOLD - 1);
  localparam logic [CW-1:0] HALF     = CW'(DIV);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_SCOL, S_SROW, S_LATCH, S_DISP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic [3:0]    row_q, row_d;
  logic [15:0]   sreg_q, sreg_d;
  logic [3:0]    row_addr_q, row_addr_d;
  logic          frame_start_q, frame_start_d;
  logic          csdi_q, csdi_d;
  logic          cclk_q, cclk_d;
  logic          rsdi_q, rsdi_d;
  logic          rclk_q, rclk_d;
  logic          le_q, le_d;
  logic          oeb_q, oeb_d;
  logic          fetch_go;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    row_d   = row_q;
    sreg_d  = sreg_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.enable) begin
          state_d = S_FETCH;
          cnt_d   = '0;
        end
      end
      S_FETCH: begin
        if (cnt_q == '0) begin
          cnt_d = CW'(1);
        end else begin
          // read data arrives one clock after row_addr was presented
          sreg_d  = bus.fb_data;
          state_d = S_SCOL;
          cnt_d   = '0;
          bit_d   = '0;
        end
      end
      S_SCOL: begin
        if (cnt_q == BIT_END) begin
          cnt_d  = '0;
          sreg_d = {sreg_q[14:0], 1'b0};
          if (bit_q == 4'd15) state_d = S_SROW;
          else                bit_d   = bit_q + 4'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_SROW: begin
        if (cnt_q == BIT_END) begin
          cnt_d   = '0;
          state_d = S_LATCH;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_LATCH: begin
        if (cnt_q == LE_END) begin
          cnt_d   = '0;
          state_d = S_DISP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DISP: begin
        if (cnt_q == HOLD_END) begin
          cnt_d   = '0;
          row_d   = row_q + 4'd1;
          state_d = bus.enable ? S_FETCH : S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered, so they are derived from the next-cycle state.
    fetch_go      = (state_d == S_FETCH) && (state_q != S_FETCH);
    row_addr_d    = fetch_go ? row_d : row_addr_q;
    frame_start_d = fetch_go && (row_d == 4'd0);
    csdi_d        = (state_d == S_SCOL) && sreg_d[15];
    cclk_d        = (state_d == S_SCOL) && (cnt_d >= HALF);
    rsdi_d        = (state_d == S_SROW) && (row_q == 4'd0);
    rclk_d        = (state_d == S_SROW) && (cnt_d >= HALF);
    le_d          = (state_d == S_LATCH);
    oeb_d         = (state_d != S_DISP);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      bit_q         <= '0;
      row_q         <= '0;
      sreg_q        <= '0;
      row_addr_q    <= '0;
      frame_start_q <= 1'b0;
      csdi_q        <= 1'b0;
      cclk_q        <= 1'b0;
      rsdi_q        <= 1'b0;
      rclk_q        <= 1'b0;
      le_q          <= 1'b0;
      oeb_q         <= 1'b1;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_q         <= bit_d;
      row_q         <= row_d;
      sreg_q        <= sreg_d;
      row_addr_q    <= row_addr_d;
      frame_start_q <= frame_start_d;
      csdi_q        <= csdi_d;
      cclk_q        <= cclk_d;
      rsdi_q        <= rsdi_d;
      rclk_q        <= rclk_d;
      le_q          <= le_d;
      oeb_q         <= oeb_d;
    end
  end

  assign bus.row_addr    = row_addr_q;
  assign bus.frame_start = frame_start_q;
  assign bus.CSDI        = csdi_q;
  assign bus.CCLK        = cclk_q;
  assign bus.RSDI        = rsdi_q;
  assign bus.RCLK        = rclk_q;
  assign bus.LE          = le_q;
  // blank acts immediately; scan timing is unaffected
  assign bus.OEB         = oeb_q | bus.blank;
endmodule

// File: tb/tb_led_matrix_scan_ctrl.sv
// Bench for led_matrix_scan_ctrl: two instances (DIV=1/HOLD=4, DIV=2/HOLD=3)
// checked each cycle against a row-timeline reference model.
module tb_led_matrix_scan_ctrl;
  localparam int D1 = 1, H1 = 4, D2 = 2, H2 = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b0;
  logic blank = 1'b0;
  int   total = 0, bad = 0, k = 0;
  logic [15:0] fb1[16], fb2[16];

  always #5 clk = ~clk;

  led_matrix_scan_ctrl_if i1();
  led_matrix_scan_ctrl_if i2();
  assign i1.enable = enable;
  assign i1.blank  = blank;
  assign i2.enable = enable;
  assign i2.blank  = blank;

  led_matrix_scan_ctrl #(.DIV(D1), .HOLD(H1)) dut1 (.clk(clk), .reset_n(reset_n), .bus(i1.master));
  led_matrix_scan_ctrl #(.DIV(D2), .HOLD(H2)) dut2 (.clk(clk), .reset_n(reset_n), .bus(i2.master));

  // synchronous-read framebuffers
  always @(posedge clk) begin
    i1.fb_data <= fb1[i1.row_addr];
    i2.fb_data <= fb2[i2.row_addr];
  end

  function automatic int dv(int i); return (i == 0) ? D1 : D2; endfunction
  function automatic int hv(int i); return (i == 0) ? H1 : H2; endfunction
  function automatic int per(int i); return 2 + 35 * dv(i) + hv(i); endfunction

  // Reference: a row is a fixed timeline of per(i) cycles starting at FETCH.
  logic       m_act[2];
  int         m_off[2];
  logic [3:0] m_row[2], m_ra[2];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        m_act[i] <= 1'b0; m_off[i] <= 0; m_row[i] <= 4'd0; m_ra[i] <= 4'd0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!m_act[i]) begin
          if (enable) begin m_act[i] <= 1'b1; m_off[i] <= 0; m_ra[i] <= m_row[i]; end
        end else if (m_off[i] == per(i) - 1) begin
          m_row[i] <= m_row[i] + 4'd1;
          if (enable) begin m_off[i] <= 0; m_ra[i] <= m_row[i] + 4'd1; end
          else m_act[i] <= 1'b0;
        end else begin
          m_off[i] <= m_off[i] + 1;
        end
      end
    end
  end

  function automatic logic [9:0] mk(logic [3:0] ra, logic fs, logic cs, logic cc,
                                    logic rs, logic rc, logic le, logic oeb);
    return {ra, fs, cs, cc, rs, rc, le, oeb};
  endfunction

  function automatic logic [9:0] exp_out(int div, logic act, int off, logic [3:0] row,
                                         logic [15:0] d, logic bl, logic [3:0] ra);
    logic fs, cs, cc, rs, rc, le, oeb;
    int p;
    fs = 0; cs = 0; cc = 0; rs = 0; rc = 0; le = 0; oeb = 1;
    if (act) begin
      if (off == 0) fs = (row == 4'd0);
      if (off >= 2 && off < 2 + 32 * div) begin
        p = off - 2; cs = d[15 - p / (2 * div)]; cc = (p % (2 * div)) >= div;
      end else if (off >= 2 + 32 * div && off < 2 + 34 * div) begin
        p = off - 2 - 32 * div; rs = (row == 4'd0); rc = p >= div;
      end else if (off >= 2 + 34 * div && off < 2 + 35 * div) begin
        le = 1;
      end else if (off >= 2 + 35 * div) begin
        oeb = bl;
      end
    end
    return mk(ra, fs, cs, cc, rs, rc, le, oeb);
  endfunction

  function automatic logic [9:0] got1();
    return mk(i1.row_addr, i1.frame_start, i1.CSDI, i1.CCLK, i1.RSDI, i1.RCLK, i1.LE, i1.OEB);
  endfunction
  function automatic logic [9:0] got2();
    return mk(i2.row_addr, i2.frame_start, i2.CSDI, i2.CCLK, i2.RSDI, i2.RCLK, i2.LE, i2.OEB);
  endfunction

  task automatic chk(string nm, logic [31:0] got, logic [31:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s k=%0d got=%h exp=%h", nm, k, got, expv);
    end
  endtask

  task automatic check_models();
    chk("model_dut1", 32'(got1()), 32'(exp_out(D1, m_act[0], m_off[0], m_row[0], fb1[m_row[0]], blank, m_ra[0])));
    chk("model_dut2", 32'(got2()), 32'(exp_out(D2, m_act[1], m_off[1], m_row[1], fb2[m_row[1]], blank, m_ra[1])));
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    k++;
    check_models();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    k = 0;
    check_models();
  endtask

  typedef struct {
    int         cyc;
    logic [9:0] expv;
  } vec_t;
  vec_t tbl[18];

  int oeb_low, fs1, fs2;

  initial begin
    // DIV=1, HOLD=4 timeline with row 0 = 16'h8001, enable held high
    tbl[0]  = '{0,   mk(4'd0, 0, 0, 0, 0, 0, 0, 1)};
    tbl[1]  = '{1,   mk(4'd0, 1, 0, 0, 0, 0, 0, 1)};
    tbl[2]  = '{2,   mk(4'd0, 0, 0, 0, 0, 0, 0, 1)};
    tbl[3]  = '{3,   mk(4'd0, 0, 1, 0, 0, 0, 0, 1)};
    tbl[4]  = '{4,   mk(4'd0, 0, 1, 1, 0, 0, 0, 1)};
    tbl[5]  = '{5,   mk(4'd0, 0, 0, 0, 0, 0, 0, 1)};
    tbl[6]  = '{6,   mk(4'd0, 0, 0, 1, 0, 0, 0, 1)};
    tbl[7]  = '{33,  mk(4'd0, 0, 1, 0, 0, 0, 0, 1)};
    tbl[8]  = '{34,  mk(4'd0, 0, 1, 1, 0, 0, 0, 1)};
    tbl[9]  = '{35,  mk(4'd0, 0, 0, 0, 1, 0, 0, 1)};
    tbl[10] = '{36,  mk(4'd0, 0, 0, 0, 1, 1, 0, 1)};
    tbl[11] = '{37,  mk(4'd0, 0, 0, 0, 0, 0, 1, 1)};
    tbl[12] = '{38,  mk(4'd0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[13] = '{41,  mk(4'd0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[14] = '{42,  mk(4'd1, 0, 0, 0, 0, 0, 0, 1)};
    tbl[15] = '{76,  mk(4'd1, 0, 0, 0, 0, 0, 0, 1)};
    tbl[16] = '{77,  mk(4'd1, 0, 0, 0, 0, 1, 0, 1)};
    tbl[17] = '{657, mk(4'd0, 1, 0, 0, 0, 0, 0, 1)};

    for (int r = 0; r < 16; r++) begin
      fb1[r] = 16'($urandom);
      fb2[r] = 16'($urandom);
    end
    fb1[0] = 16'h8001;

    // vector table
    enable = 1'b1;
    blank  = 1'b0;
    do_reset();
    for (int t = 0; t < 18; t++) begin
      while (k < tbl[t].cyc) step();
      chk($sformatf("tbl%0d", t), 32'(got1()), 32'(tbl[t].expv));
    end

    // enable drops mid column shift on row 5
    do_reset();
    while (k < 216) step();
    chk("row5_shifting", 32'(i1.row_addr), 32'd5);
    enable = 1'b0;
    while (k < 247) step();
    chk("row5_idle", 32'({i1.row_addr, i1.OEB}), 32'({4'd5, 1'b1}));
    while (k < 260) step();
    chk("still_idle", 32'({i1.OEB, i1.CCLK, i1.LE}), 32'(3'b100));
    enable = 1'b1;
    step();
    chk("resume_row6", 32'({i1.row_addr, i1.frame_start}), 32'({4'd6, 1'b0}));

    // async reset in the middle of a column shift
    while (k < 270) step();
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_dut1", 32'(got1()), 32'(mk(4'd0, 0, 0, 0, 0, 0, 0, 1)));
    chk("async_rst_dut2", 32'(got2()), 32'(mk(4'd0, 0, 0, 0, 0, 0, 0, 1)));
    @(negedge clk);
    reset_n = 1'b1;
    k = 0;
    check_models();
    step();
    chk("restart_fs", 32'({i1.row_addr, i1.frame_start}), 32'({4'd0, 1'b1}));

    // blank held high for more than one DIV=1 frame
    blank = 1'b1;
    do_reset();
    oeb_low = 0; fs1 = 0; fs2 = 0;
    for (int c = 0; c < 700; c++) begin
      step();
      if (!i1.OEB || !i2.OEB) oeb_low++;
      if (i1.frame_start) fs1++;
      if (i2.frame_start) fs2++;
    end
    chk("blank_oeb_low", 32'(oeb_low), 32'd0);
    chk("blank_fs_dut1", 32'(fs1), 32'd2);
    chk("blank_fs_dut2", 32'(fs2), 32'd1);

    // random framebuffer, enable and blank
    reset_n = 1'b0;
    for (int r = 0; r < 16; r++) begin
      fb1[r] = 16'($urandom);
      fb2[r] = 16'($urandom);
    end
    blank  = 1'b0;
    enable = 1'b1;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      step();
      if ($urandom_range(0, 49) == 0) enable = ~enable;
      if ($urandom_range(0, 29) == 0) blank  = ~blank;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/led_matrix_scan_ctrl.md
Name: led_matrix_scan_ctrl

Overview:
Row-scan sequencer for the 16x16 LED matrix. Drives the two daisy-chained shift registers: column data on CSDI/CCLK, row select on RSDI/RCLK, common latch LE and output-enable OEB. Reads one 16-bit row per scan step from the game's framebuffer through a synchronous read port. Emits a frame-start strobe so game logic can update the framebuffer between frames.

Parameters:
DIV, 2, system clocks per shift-clock half-period (>=1); also the LE pulse width.
HOLD, 256, system clocks a row stays lit (OEB low) per scan step (>=1).

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
enable  input  1  scanning allowed; sampled in IDLE and at end of DISPLAY
blank  input  1  forces OEB high while asserted; scan timing continues
row_addr  output  4  framebuffer row read address
fb_data  input  16  framebuffer row data, valid 1 clk after row_addr; bit n = column n, 1 = lit
frame_start  output  1  1-clk pulse on entering FETCH for row 0
CSDI  output  1  column serial data
CCLK  output  1  column shift clock, rising-edge shift
RSDI  output  1  row serial data
RCLK  output  1  row shift clock, rising-edge shift
LE  output  1  latch enable, active high
OEB  output  1  output enable, active low

Behaviour:
- Reset (async, reset_n low): state IDLE, row=0, all outputs 0 except OEB=1; internal counters cleared. Reset mid-shift aborts immediately; no partial LE pulse.
- States: IDLE -> FETCH -> SHIFT_COL -> SHIFT_ROW -> LATCH -> DISPLAY -> FETCH (next row) or IDLE.
- IDLE: OEB=1, clocks low. If enable=1, go to FETCH next cycle.
- FETCH, 2 clks: cycle 1 row_addr=row (frame_start=1 if row==0); cycle 2 capture fb_data into shift register. row_addr holds its value outside FETCH.
- SHIFT_COL, 32*DIV clks: 16 bits, column 15 first, column 0 last. Per bit: CSDI set at bit start; CCLK low DIV clks, then high DIV clks. CSDI stable for the whole bit period.
- SHIFT_ROW, 2*DIV clks: one bit, RSDI=1 iff row==0, else 0; RCLK low DIV, high DIV. This walks a single 1 through the row register; the row-0 reinjection keeps it aligned to the frame.
- LATCH, DIV clks: LE=1; CSDI/RSDI/CCLK/RCLK low.
- DISPLAY, HOLD clks: OEB = blank. On the last cycle, row increments mod 16 (15 wraps to 0). If enable=1 go to FETCH, else IDLE.
- OEB=1 in every state except DISPLAY; display is blanked during shifting.
- enable deassert outside IDLE/DISPLAY-end is ignored: the current row completes.
- Leaving IDLE keeps the current row (no reset to 0); the frame resumes where it stopped.
- Cycles per row = 2 + 35*DIV + HOLD; per frame = 16x that.
- Counters sized by $clog2 of the larger of 32*DIV and HOLD; no overflow at parameter extremes.

Test Plan:
- DIV=1, HOLD=4, enable=1 from reset: frame_start at cycle 1 after reset release; LE high exactly 1 clk at row offset 36; OEB low 4 clks; row period = 41 clks; frame_start period = 656 clks.
- fb_data=16'h8001 for row 0: CSDI high on first and last bit periods only; 16 CCLK rising edges; 1 RCLK edge with RSDI=1 for row 0 and RSDI=0 for rows 1..15.
- DIV=2: CCLK low 2 / high 2 clks; SHIFT_COL lasts 64 clks; LE width 2 clks.
- blank=1 throughout: OEB never low; row_addr still sequences 0..15 and wraps to 0; frame_start still pulses.
- enable drops mid-SHIFT_COL on row 5: row 5 completes through DISPLAY, then IDLE with OEB=1; re-enable -> FETCH with row_addr=6, no frame_start.
- reset_n asserted mid-SHIFT_COL: all outputs go to reset values immediately without waiting for clk (OEB=1, others 0); after release, the scan restarts at row 0 with frame_start.
